// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
//   Scans a 4x4 membrane keypad one row at a time and synchronizes the column
//   returns. It assembles a 16-bit frame per full scan and debounces whole
//   frames. It then presents 16 clean active-low key lines to the downstream
//   priority encoder. Multiple keys pass through unchanged, and ghost
//   rectangles are reported exactly as read.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   col_n[3:0] keypad columns, active-low, asynchronous to clk
//   row_n[3:0] row drive, exactly one bit low (row r on row_n[r])
//   key_15_8   debounced keys 15..8, active-low (bit i = key 8+i)
//   key_7_0    debounced keys 7..0, active-low (bit i = key i)
//   key_valid  one-clock pulse when the debounced key set changes
//   key_any    high while any debounced key is pressed
//
// Key index = row*4 + col.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV       = 1000,  // clocks per row slot, >= 4
  parameter int DEBOUNCE_SCANS = 4      // identical frames needed, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] key_15_8,
  output logic [7:0] key_7_0,
  output logic       key_valid,
  output logic       key_any
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB      = 4'(DEBOUNCE_SCANS);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      keys_q, keys_d;
  logic             valid_q, valid_d;
  logic             any_q, any_d;

  logic             tick;
  logic             frame_end;
  logic [15:0]      raw;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sync1_d   = col_n;
    sync2_d   = sync1_q;
    tick      = (div_q == DIV_LAST);
    frame_end = tick && (row_q == 2'd3);
    div_d     = tick ? '0 : div_q + 1'b1;
    row_d     = tick ? row_q + 2'd1 : row_q;
    // Row drive follows the row counter one clock after the tick.
    row_n_d   = ~(4'b0001 << row_d);

    frame_d = frame_q;
    if (tick) begin
      frame_d[{row_q, 2'b00} +: 4] = sync2_q;
    end

    // Row 3 is captured at the same tick that ends the frame, so the
    // complete frame is taken from the live synchronizer output.
    raw = {sync2_q, frame_q[11:0]};

    cand_d  = cand_q;
    cnt_d   = cnt_q;
    keys_d  = keys_q;
    valid_d = 1'b0;
    if (frame_end) begin
      if (raw == cand_q) begin
        // The count saturates, so a held set never triggers a repeat update.
        cnt_d = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
      end else begin
        cand_d = raw;
        cnt_d  = 4'd1;
      end
      if ((cnt_d == DEB) && (cand_d != keys_q)) begin
        keys_d  = cand_d;
        valid_d = 1'b1;
      end
    end

    // key_any is computed from the next outputs so it moves with them.
    any_d = ~&keys_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      div_q   <= '0;
      row_q   <= 2'd0;
      row_n_q <= 4'b1110;
      frame_q <= 16'hFFFF;
      cand_q  <= 16'hFFFF;
      cnt_q   <= 4'd0;
      keys_q  <= 16'hFFFF;
      valid_q <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      row_q   <= row_d;
      row_n_q <= row_n_d;
      frame_q <= frame_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
      valid_q <= valid_d;
      any_q   <= any_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_15_8  = keys_q[15:8];
  assign key_7_0   = keys_q[7:0];
  assign key_valid = valid_q;
  assign key_any   = any_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Testbench for keypad_scan_4x4 with SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one
// frame is 16 clocks. A physical keypad is modelled from a pressed-key mask.
// Directed frames come from a table. The bench then runs a mid-scan reset
// sequence, followed by random frames checked against a frame-history model.
module tb_keypad_scan_4x4;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] key_15_8;
  logic [7:0] key_7_0;
  logic       key_valid;
  logic       key_any;

  logic [15:0] pressed = 16'h0000;  // 1 = key held down

  int tests = 0;
  int fails = 0;

  keypad_scan_4x4 #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_15_8  (key_15_8),
    .key_7_0   (key_7_0),
    .key_valid (key_valid),
    .key_any   (key_any)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column. Only the low row pulls
  // columns down, and pull-ups hold every other column high.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_n[r] == 1'b0) col_n = col_n & ~pressed[r*4 +: 4];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Holds 'mask' for one full frame, starting from the negedge in the
  // div=0 cycle of row 0. It then checks the outputs after the frame end,
  // including the number of key_valid pulses produced by that frame end.
  task automatic run_frame(input logic [15:0] mask, input logic [7:0] e15,
                           input logic [7:0] e7, input int ev, input string tag);
    int nv;
    nv      = 0;
    pressed = mask;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) nv++;
      check($sformatf("%s row_n@%0d", tag, k), {28'd0, row_n},
            {28'd0, ~(4'b0001 << ((k / SCAN_DIV) % 4))});
    end
    check({tag, " key_15_8"}, {24'd0, key_15_8}, {24'd0, e15});
    check({tag, " key_7_0"},  {24'd0, key_7_0},  {24'd0, e7});
    check({tag, " key_any"},  {31'd0, key_any},  {31'd0, ({e15, e7} != 16'hFFFF)});
    check({tag, " valid_pulses"}, nv, ev);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " row_n"},     {28'd0, row_n},     32'hE);
    check({tag, " key_15_8"},  {24'd0, key_15_8},  32'hFF);
    check({tag, " key_7_0"},   {24'd0, key_7_0},   32'hFF);
    check({tag, " key_valid"}, {31'd0, key_valid}, 32'h0);
    check({tag, " key_any"},   {31'd0, key_any},   32'h0);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(tag);
  endtask

  // Reference model: outputs follow a key set only once the last DEB frames
  // since reset were all identical to it.
  logic [15:0] hist[$];
  logic [15:0] m_keys;

  task automatic model_frame(input logic [15:0] mask, output logic [7:0] e15,
                             output logic [7:0] e7, output int ev);
    bit same;
    hist.push_back(mask);
    ev = 0;
    if (hist.size() >= DEB) begin
      same = 1'b1;
      for (int i = 1; i < DEB; i++) begin
        if (hist[hist.size() - 1 - i] != mask) same = 1'b0;
      end
      if (same && (~mask != m_keys)) begin
        m_keys = ~mask;
        ev     = 1;
      end
    end
    e15 = m_keys[15:8];
    e7  = m_keys[7:0];
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [7:0]  e15;
    logic [7:0]  e7;
    int          ev;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] mask;
    logic [7:0]  e15;
    logic [7:0]  e7;
    int          ev;

    // Rotation with nothing pressed
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 0});
    // Single key 15 for three frames, then release
    vecs.push_back('{16'h8000, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h8000, 8'h7F, 8'hFF, 1});
    vecs.push_back('{16'h8000, 8'h7F, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'h7F, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 1});
    // Key 5 bouncing on alternate frames never settles
    vecs.push_back('{16'h0020, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0020, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0020, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 0});
    // Keys 0 and 9 together, then release of both
    vecs.push_back('{16'h0201, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0201, 8'hFD, 8'hFE, 1});
    vecs.push_back('{16'h0201, 8'hFD, 8'hFE, 0});
    vecs.push_back('{16'h0000, 8'hFD, 8'hFE, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 1});
    // Ghost rectangle keys 0,1,4,5 are reported as read
    vecs.push_back('{16'h0033, 8'hFF, 8'hFF, 0});
    vecs.push_back('{16'h0033, 8'hFF, 8'hCC, 1});
    vecs.push_back('{16'h0000, 8'hFF, 8'hCC, 0});
    vecs.push_back('{16'h0000, 8'hFF, 8'hFF, 1});

    // Reset held for 3 clocks from time zero
    pressed = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_frame(vecs[i].keys, vecs[i].e15, vecs[i].e7, vecs[i].ev,
                $sformatf("vec%0d", i));
    end

    // Reset mid-scan: debounce key 15, then reset during row 2
    run_frame(16'h8000, 8'hFF, 8'hFF, 0, "mid_a");
    run_frame(16'h8000, 8'h7F, 8'hFF, 1, "mid_b");
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid row2 row_n", {28'd0, row_n}, 32'hB);
    check("mid row2 key_15_8", {24'd0, key_15_8}, 32'h7F);
    do_reset(1, "mid_rst");
    run_frame(16'h8000, 8'hFF, 8'hFF, 0, "mid_c");
    run_frame(16'h8000, 8'h7F, 8'hFF, 1, "mid_d");

    // Random frames against the model, from a clean reset
    do_reset(2, "rand_rst");
    hist.delete();
    m_keys = 16'hFFFF;
    mask   = 16'h0000;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    mask = mask;
        2:       mask = 16'h0001 << $urandom_range(0, 15);
        3:       mask = 16'($urandom) & 16'($urandom);
        default: mask = 16'h0000;
      endcase
      model_frame(mask, e15, e7, ev);
      run_frame(mask, e15, e7, ev, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
